// File: rtl/pipeline_arith_pkg.sv
// Shared opcode encodings for the pipelined arithmetic stream.
package pipeline_arith_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/pipeline_arith_stream_arith_core.sv
// Combinational compute stage: add/sub/mul/div on W-bit operands, 2*W-bit result.
// Division returns {remainder, quotient}; signed division works on magnitudes
// and re-applies signs, so it truncates toward zero with the remainder taking the sign of A.
module arith_core
   import pipeline_arith_pkg::*;
#(
   parameter int W      = 8,
   parameter int SIGNED = 0
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [1:0]     op,
   output logic [2*W-1:0] result,
   output logic           err
);

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   logic [2*W-1:0] ax, bx;
   logic           sa, sb;
   logic [W-1:0]   ma, mb, mq, mr, quot, rem;

   // Operand extension plus magnitude-based divider.
   always_comb begin
      sa   = (SIGNED != 0) && a[W-1];
      sb   = (SIGNED != 0) && b[W-1];
      ax   = sa ? {{W{1'b1}}, a} : {{W{1'b0}}, a};
      bx   = sb ? {{W{1'b1}}, b} : {{W{1'b0}}, b};
      ma   = sa ? (~a + 1'b1) : a;
      mb   = sb ? (~b + 1'b1) : b;
      // Most-negative / -1 yields magnitude 2^(W-1), which re-signs to A itself.
      mq   = ma / mb;
      mr   = ma % mb;
      quot = (sa ^ sb) ? (~mq + 1'b1) : mq;
      rem  = sa ? (~mr + 1'b1) : mr;
   end

   // Result select and error flagging.
   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         OP_ADD: result = ax + bx;
         OP_SUB: result = ax - bx;
         OP_MUL: result = ax * bx;
         default: begin
            if (b == '0) begin
               result = {a, {W{1'b1}}};
               err    = 1'b1;
            end else begin
               result = {rem, quot};
               err    = (SIGNED != 0) && (a == MOST_NEG) && (b == '1);
            end
         end
      endcase
   end

endmodule

// File: rtl/pipeline_arith_stream.sv
// Three-stage pipelined ALU with valid/ready handshakes. All stages advance
// together whenever the output register is empty or being drained.
module pipeline_arith_stream
   import pipeline_arith_pkg::*;
#(
   parameter int W      = 8,
   parameter int TAG_W  = 4,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   logic             adv;
   logic             s1_vld_q, s2_vld_q, s3_vld_q;
   logic [W-1:0]     s1_a_q, s1_b_q;
   logic [1:0]       s1_op_q;
   logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
   logic [2*W-1:0]   core_res, s2_res_q, s3_res_q;
   logic             core_err, s2_err_q, s3_err_q;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   assign adv      = !s3_vld_q || out_ready;
   assign in_ready = adv;

   arith_core #(.W(W), .SIGNED(SIGNED)) u_core (
      .a      (s1_a_q),
      .b      (s1_b_q),
      .op     (s1_op_q),
      .result (core_res),
      .err    (core_err)
   );

   // Pipeline registers: whole pipe shifts on adv, freezes otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q <= 1'b0;  s1_a_q <= '0;  s1_b_q <= '0;  s1_op_q <= '0;  s1_tag_q <= '0;
         s2_vld_q <= 1'b0;  s2_res_q <= '0;  s2_err_q <= 1'b0;  s2_tag_q <= '0;
         s3_vld_q <= 1'b0;  s3_res_q <= '0;  s3_err_q <= 1'b0;  s3_tag_q <= '0;
      end else if (adv) begin
         s1_vld_q <= in_valid;
         s1_a_q   <= in_a;
         s1_b_q   <= in_b;
         s1_op_q  <= in_op;
         s1_tag_q <= in_tag;
         s2_vld_q <= s1_vld_q;
         s2_res_q <= core_res;
         s2_err_q <= core_err;
         s2_tag_q <= s1_tag_q;
         s3_vld_q <= s2_vld_q;
         s3_res_q <= s2_res_q;
         s3_err_q <= s2_err_q;
         s3_tag_q <= s2_tag_q;
      end
   end

   // Saturating count of errored results actually handed to the consumer.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (s3_vld_q && out_ready && s3_err_q && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // Error counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign out_valid  = s3_vld_q;
   assign out_result = s3_res_q;
   assign out_tag    = s3_tag_q;
   assign out_err    = s3_err_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_pipeline_arith_stream.sv
// Bench for pipeline_arith_stream: three instances (unsigned, signed, 2-bit counter),
// scoreboard queues filled on accepted beats and drained on output handshakes.
module tb_pipeline_arith_stream;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  tag;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  ivld;
   logic [2:0]  rdy, vld;
   logic        ordy;
   logic [7:0]  a, b;
   logic [1:0]  op;
   logic [3:0]  tag;
   logic [15:0] res [3];
   logic [3:0]  otag [3];
   logic [2:0]  oerr;
   logic [7:0]  cnt [3];
   logic [1:0]  cnt2;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_lat;

   exp_t        sb [3][$];
   int          exp_cnt [3];
   bit          held [3];
   logic [15:0] h_res [3];
   logic [3:0]  h_tag [3];
   logic        h_err [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipeline_arith_stream #(.W(8), .TAG_W(4), .SIGNED(0), .CNT_W(8)) u0 (
      .clk(clk), .reset_n(reset_n), .in_valid(ivld[0]), .in_ready(rdy[0]),
      .in_a(a), .in_b(b), .in_op(op), .in_tag(tag),
      .out_valid(vld[0]), .out_ready(ordy), .out_result(res[0]), .out_tag(otag[0]),
      .out_err(oerr[0]), .err_count(cnt[0]));

   pipeline_arith_stream #(.W(8), .TAG_W(4), .SIGNED(1), .CNT_W(8)) u1 (
      .clk(clk), .reset_n(reset_n), .in_valid(ivld[1]), .in_ready(rdy[1]),
      .in_a(a), .in_b(b), .in_op(op), .in_tag(tag),
      .out_valid(vld[1]), .out_ready(ordy), .out_result(res[1]), .out_tag(otag[1]),
      .out_err(oerr[1]), .err_count(cnt[1]));

   pipeline_arith_stream #(.W(8), .TAG_W(4), .SIGNED(0), .CNT_W(2)) u2 (
      .clk(clk), .reset_n(reset_n), .in_valid(ivld[2]), .in_ready(rdy[2]),
      .in_a(a), .in_b(b), .in_op(op), .in_tag(tag),
      .out_valid(vld[2]), .out_ready(ordy), .out_result(res[2]), .out_tag(otag[2]),
      .out_err(oerr[2]), .err_count(cnt2));

   assign cnt[2] = {6'b0, cnt2};

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", name, obs, expv);
      end
   endtask

   // Reference arithmetic: returns {err, result}.
   function automatic logic [16:0] model(logic [7:0] x, logic [7:0] y, logic [1:0] o, bit sgn);
      int sx, sy, q, r;
      logic [15:0] rv;
      logic e;
      e  = 1'b0;
      sx = sgn ? int'($signed(x)) : int'(x);
      sy = sgn ? int'($signed(y)) : int'(y);
      case (o)
         2'd0: rv = 16'(sx + sy);
         2'd1: rv = 16'(sx - sy);
         2'd2: rv = 16'(sx * sy);
         default: begin
            if (sy == 0) begin
               rv = {x, 8'hFF}; e = 1'b1;
            end else if (sgn && sx == -128 && sy == -1) begin
               rv = 16'h0080; e = 1'b1;
            end else begin
               q = sx / sy; r = sx % sy;
               rv = {r[7:0], q[7:0]};
            end
         end
      endcase
      return {e, rv};
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            exp_cnt[k] = 0;
            held[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(!vld[k] || ordy));
            check($sformatf("err_count%0d", k), 32'(cnt[k]), 32'(exp_cnt[k]));
            if (held[k]) begin
               check($sformatf("hold_vld%0d", k), 32'(vld[k]), 32'd1);
               check($sformatf("hold_res%0d", k), 32'(res[k]), 32'(h_res[k]));
               check($sformatf("hold_tag%0d", k), 32'(otag[k]), 32'(h_tag[k]));
               check($sformatf("hold_err%0d", k), 32'(oerr[k]), 32'(h_err[k]));
            end
            if (vld[k] && ordy) begin
               if (sb[k].size() == 0) begin
                  check($sformatf("unexpected_out%0d", k), 32'(res[k]), 32'hDEAD_0000);
               end else begin
                  exp_t e;
                  e = sb[k].pop_front();
                  check($sformatf("result%0d", k), 32'(res[k]), 32'(e.res));
                  check($sformatf("tag%0d", k), 32'(otag[k]), 32'(e.tag));
                  check($sformatf("err%0d", k), 32'(oerr[k]), 32'(e.err));
                  // Accepted at edge N, handshaken at edge N+3 when unstalled.
                  if (chk_lat) check($sformatf("latency%0d", k), 32'(cyc + 1), 32'(e.acc + 3));
                  if (e.err && exp_cnt[k] < ((k == 2) ? 3 : 255)) exp_cnt[k]++;
               end
            end
            held[k]  = vld[k] && !ordy;
            h_res[k] = res[k];
            h_tag[k] = otag[k];
            h_err[k] = oerr[k];
            if (ivld[k] && rdy[k]) begin
               exp_t n;
               logic [16:0] m;
               m = model(a, b, op, k == 1);
               n.res = m[15:0]; n.err = m[16]; n.tag = tag; n.acc = cyc + 1;
               sb[k].push_back(n);
            end
         end
      end
   end

   // Present one beat to instance k and hold it until accepted.
   task automatic send(input int k, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [1:0] xo, input logic [3:0] xt);
      bit ok;
      ivld = 3'b000; ivld[k] = 1'b1;
      a = xa; b = xb; op = xo; tag = xt;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk); ok = rdy[k];
         @(posedge clk); #1;
         if (ok) return;
      end
      check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      ivld = 3'b000;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; ivld = 3'b000; ordy = 1'b1; chk_lat = 1'b1;
      a = '0; b = '0; op = '0; tag = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_vld", 32'(vld[k]), 32'd0);
         check("rst_res", 32'(res[k]), 32'd0);
         check("rst_cnt", 32'(cnt[k]), 32'd0);
         check("rst_rdy", 32'(rdy[k]), 32'd1);
      end
      reset_n = 1'b1;
      idle(1);

      // 1: back-to-back add/sub/mul/div
      send(0, 8'd5, 8'd3, 2'd0, 4'd1);
      send(0, 8'd10, 8'd4, 2'd1, 4'd2);
      send(0, 8'd12, 8'd2, 2'd2, 4'd3);
      send(0, 8'd8, 8'd2, 2'd3, 4'd4);
      idle(6);

      // 2: divide by zero, then negative unsigned difference
      send(0, 8'd15, 8'd0, 2'd3, 4'd5);
      send(0, 8'd3, 8'd5, 2'd1, 4'd6);
      idle(6);

      // 3: backpressure mid-stream
      chk_lat = 1'b0;
      fork
         begin
            send(0, 8'd200, 8'd100, 2'd0, 4'd7);
            send(0, 8'd9, 8'd200, 2'd1, 4'd8);
            send(0, 8'd255, 8'd255, 2'd2, 4'd9);
            send(0, 8'd250, 8'd7, 2'd3, 4'd10);
            send(0, 8'd1, 8'd0, 2'd3, 4'd11);
            send(0, 8'd77, 8'd11, 2'd2, 4'd12);
            ivld = 3'b000;
         end
         begin
            repeat (4) @(posedge clk);
            #1 ordy = 1'b0;
            repeat (4) @(posedge clk);
            #1 ordy = 1'b1;
         end
      join
      idle(8);
      check("bp_drained", 32'(sb[0].size()), 32'd0);
      chk_lat = 1'b1;

      // 4: signed instance
      send(1, 8'hF9, 8'd2, 2'd3, 4'd1);
      send(1, 8'h80, 8'hFF, 2'd3, 4'd2);
      send(1, 8'hFE, 8'd3, 2'd2, 4'd3);
      send(1, 8'h07, 8'hFE, 2'd3, 4'd4);
      send(1, 8'hFD, 8'h01, 2'd0, 4'd5);
      send(1, 8'h80, 8'h00, 2'd3, 4'd6);
      idle(6);

      // 5: 2-bit counter saturation
      for (int i = 0; i < 5; i++) send(2, 8'(i + 1), 8'd0, 2'd3, 4'(i));
      idle(6);
      check("sat_cnt", 32'(cnt[2]), 32'd3);

      // 6: reset with beats in flight
      send(0, 8'd1, 8'd2, 2'd0, 4'd1);
      send(0, 8'd3, 8'd0, 2'd3, 4'd2);
      send(0, 8'd5, 8'd6, 2'd2, 4'd3);
      ivld = 3'b000;
      reset_n = 1'b0;
      #1;
      check("mid_rst_vld", 32'(vld[0]), 32'd0);
      check("mid_rst_res", 32'(res[0]), 32'd0);
      check("mid_rst_tag", 32'(otag[0]), 32'd0);
      check("mid_rst_err", 32'(oerr[0]), 32'd0);
      check("mid_rst_cnt", 32'(cnt[0]), 32'd0);
      check("mid_rst_rdy", 32'(rdy[0]), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(6);
      send(0, 8'd40, 8'd2, 2'd1, 4'd9);
      idle(8);

      for (int k = 0; k < 3; k++) check("final_drained", 32'(sb[k].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
